// File: rtl/mips_pkg.sv
// mips_pkg: shared branch opcodes, forwarding select codes, FSM states and operand helpers
package mips_pkg;
  typedef enum logic [2:0] {BR_NONE, BR_BEQ, BR_BNE, BR_BLEZ, BR_BGTZ, BR_BLTZ, BR_BGEZ, BR_J} br_op_e;
  typedef enum logic [1:0] {SRC_RF, SRC_EX, SRC_MEM, SRC_WB} cmpsrc_e;
  typedef enum logic [1:0] {S_RUN, S_HOLD, S_REDIRECT} state_e;
  function automatic logic [31:0] fwd_sel(input logic [1:0] sel, input logic [31:0] rf, ex, mem, wb);
    return sel == SRC_RF ? rf : sel == SRC_EX ? ex : sel == SRC_MEM ? mem : wb;
  endfunction
  function automatic logic load_hit(input logic [1:0] sel, input logic ex_ld, mem_ld);
    return (sel == SRC_EX && ex_ld) || (sel == SRC_MEM && mem_ld);
  endfunction
endpackage

// File: rtl/branch_resolve_if.sv
// branch_resolve_if: ID-stage branch operands, forwarding selects, redirect and counter outputs
interface branch_resolve_if #(parameter int CNT_W = 32);
  logic             id_valid;
  logic [2:0]       br_op;
  logic [31:0]      pc_plus4;
  logic [15:0]      imm;
  logic [25:0]      jidx;
  logic [31:0]      rs_data, rt_data, ex_result, mem_result, wb_data;
  logic [1:0]       cmpsrc1, cmpsrc2;
  logic             ex_memread, mem_memread;
  logic             stall_id, id_kill, redirect_valid, flush_ifid;
  logic [31:0]      redirect_pc;
  logic [CNT_W-1:0] br_cnt, taken_cnt, stall_cnt;
  modport master (
    output id_valid, br_op, pc_plus4, imm, jidx, rs_data, rt_data, ex_result, mem_result, wb_data,
           cmpsrc1, cmpsrc2, ex_memread, mem_memread,
    input  stall_id, id_kill, redirect_valid, flush_ifid, redirect_pc, br_cnt, taken_cnt, stall_cnt
  );
  modport slave (
    input  id_valid, br_op, pc_plus4, imm, jidx, rs_data, rt_data, ex_result, mem_result, wb_data,
           cmpsrc1, cmpsrc2, ex_memread, mem_memread,
    output stall_id, id_kill, redirect_valid, flush_ifid, redirect_pc, br_cnt, taken_cnt, stall_cnt
  );
endinterface

// File: rtl/branch_resolve_cond.sv
// branch_cond: branch/jump condition, operand usage and target computation
module branch_cond
  import mips_pkg::*;
(
  input  logic [2:0]  br_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] pc_plus4,
  input  logic [15:0] imm,
  input  logic [25:0] jidx,
  output logic        taken,
  output logic        use_a,
  output logic        use_b,
  output logic [31:0] target
);
  logic a_zero;
  assign a_zero = a == '0;
  assign use_b  = br_op == BR_BEQ || br_op == BR_BNE;
  assign use_a  = br_op != BR_NONE && br_op != BR_J;
  assign taken  = br_op == BR_BEQ  ? a == b :
                  br_op == BR_BNE  ? a != b :
                  br_op == BR_BLEZ ? a[31] | a_zero :
                  br_op == BR_BGTZ ? !a[31] & !a_zero :
                  br_op == BR_BLTZ ? a[31] :
                  br_op == BR_BGEZ ? !a[31] :
                  br_op == BR_J;
  assign target = br_op == BR_J ? {pc_plus4[31:28], jidx, 2'b00}
                                : pc_plus4 + {{14{imm[15]}}, imm, 2'b00};
endmodule

// File: rtl/branch_resolve.sv
// branch_resolve: ID-stage branch resolution with load-use stall, registered redirect and perf counters
module branch_resolve
  import mips_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  branch_resolve_if.slave bus
);
  state_e           state_q, state_d;
  logic [31:0]      a, b, target, redirect_pc_q;
  logic [CNT_W-1:0] br_cnt_q, taken_cnt_q, stall_cnt_q;
  logic             taken, use_a, use_b, hz, is_br, resolve, stall;
  assign a = fwd_sel(bus.cmpsrc1, bus.rs_data, bus.ex_result, bus.mem_result, bus.wb_data);
  assign b = fwd_sel(bus.cmpsrc2, bus.rt_data, bus.ex_result, bus.mem_result, bus.wb_data);
  branch_cond u_cond (
    .br_op(bus.br_op), .a(a), .b(b), .pc_plus4(bus.pc_plus4), .imm(bus.imm), .jidx(bus.jidx),
    .taken(taken), .use_a(use_a), .use_b(use_b), .target(target)
  );
  assign hz      = (use_a && load_hit(bus.cmpsrc1, bus.ex_memread, bus.mem_memread)) ||
                   (use_b && load_hit(bus.cmpsrc2, bus.ex_memread, bus.mem_memread));
  assign is_br   = bus.id_valid && bus.br_op != BR_NONE && state_q != S_REDIRECT;
  assign resolve = is_br && !hz;
  // gated by rst_n so the stall drops together with the rest of the outputs during reset
  assign stall   = rst_n && is_br && hz;
  always_comb begin
    state_d = !is_br ? S_RUN : hz ? S_HOLD : taken ? S_REDIRECT : S_RUN;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_RUN;
      redirect_pc_q <= '0;
      br_cnt_q      <= '0;
      taken_cnt_q   <= '0;
      stall_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      redirect_pc_q <= state_d == S_REDIRECT ? target : redirect_pc_q;
      br_cnt_q      <= br_cnt_q + CNT_W'(resolve);
      taken_cnt_q   <= taken_cnt_q + CNT_W'(resolve && taken);
      stall_cnt_q   <= stall_cnt_q + CNT_W'(stall);
    end
  end
  assign bus.stall_id       = stall;
  assign bus.id_kill        = state_q == S_REDIRECT;
  assign bus.redirect_valid = state_q == S_REDIRECT;
  assign bus.flush_ifid     = state_q == S_REDIRECT;
  assign bus.redirect_pc    = redirect_pc_q;
  assign bus.br_cnt         = br_cnt_q;
  assign bus.taken_cnt      = taken_cnt_q;
  assign bus.stall_cnt      = stall_cnt_q;
endmodule

// File: doc/branch_resolve.md
# branch_resolve

ID-stage branch resolution unit for the 5-stage MIPS pipeline. It consumes the comparator-operand select codes from the branch forwarding unit (cmpsrc1/cmpsrc2) and selects the forwarded operands. It evaluates the branch or jump condition and stalls ID while a load producer's data is not yet available. It issues a registered PC redirect with a two-slot squash. It also keeps branch performance counters.

## Interface
Parameters:
- `CNT_W`, 32: width of the performance counters.

Ports:
- `clk`  in  1  pipeline clock.
- `rst_n`  in  1  reset. One clock; reset is asynchronous and active-low.
- `id_valid`  in  1  ID holds a real instruction.
- `br_op`  in  3  encoding: 000 none, 001 BEQ, 010 BNE, 011 BLEZ, 100 BGTZ, 101 BLTZ, 110 BGEZ, 111 J.
- `pc_plus4`  in  32  PC+4 of the ID instruction.
- `imm`  in  16  branch offset.
- `jidx`  in  26  jump index.
- `rs_data`, `rt_data`  in  32 each  register-file read data.
- `ex_result`  in  32  EX ALU result.
- `mem_result`  in  32  MEM forwarded data.
- `wb_data`  in  32  WB write data.
- `cmpsrc1`, `cmpsrc2`  in  2 each  select codes: 00 regfile, 01 EX, 10 MEM, 11 WB.
- `ex_memread`, `mem_memread`  in  1 each  the producer in that stage is a load.
- `stall_id`  out  1  hold PC and IF/ID; insert a bubble into EX.
- `id_kill`  out  1  turn the current ID instruction into a bubble.
- `redirect_valid`  out  1  load `redirect_pc` into the PC this cycle.
- `redirect_pc`  out  32  branch or jump target.
- `flush_ifid`  out  1  invalidate the IF/ID register at the next edge.
- `br_cnt`, `taken_cnt`, `stall_cnt`  out  CNT_W each  performance counters.

## Operation
- `is_br` = `id_valid` & (`br_op` != 000) & (state != REDIRECT).
- Operand A = mux(`cmpsrc1`) over {`rs_data`, `ex_result`, `mem_result`, `wb_data`}. Operand B uses the same mux under `cmpsrc2`.
- B is used only by BEQ and BNE. J uses no operands.
- Conditions:
  - BEQ: A==B.
  - BNE: A!=B.
  - BLEZ: A[31] | (A==0).
  - BGTZ: !A[31] & (A!=0).
  - BLTZ: A[31].
  - BGEZ: !A[31].
  - J: always taken.
- Target:
  - Branches: `pc_plus4` + (sign-extended `imm` << 2), mod 2^32.
  - J: {`pc_plus4`[31:28], `jidx`, 2'b00}.
- A hazard exists if a used operand has (sel==01 & `ex_memread`) or (sel==10 & `mem_memread`).
- `stall_id` = `is_br` & hazard, combinational.
- FSM states:
  - RUN:
    - `is_br` & hazard → HOLD.
    - `is_br` & !hazard & taken → REDIRECT.
    - Otherwise stay in RUN.
  - HOLD:
    - hazard persists → HOLD.
    - hazard clear & taken → REDIRECT.
    - hazard clear & !taken → RUN.
    - `id_valid` dropping to 0 → RUN. This is an external flush.
  - REDIRECT: lasts one cycle, then → RUN. `id_kill`=1 in this state; ID holds wrong-path PC+4 and is ignored even if it is a branch. No counter updates.
- Target and redirect are registered: entering REDIRECT latches the target into `redirect_pc`.
- No branch delay slot exists.
- Counters wrap modulo 2^CNT_W:
  - `br_cnt` increments once per resolved branch or jump (cycle of resolution).
  - `taken_cnt` increments when the resolved branch is taken.
  - `stall_cnt` increments every cycle `stall_id`=1.

## Timing
- Reset state: RUN. `stall_id`, `id_kill`, `redirect_valid`, and `flush_ifid` are 0. `redirect_pc` = 0. All counters = 0.
- Resolve in cycle N. For taken: `redirect_valid`=1, `flush_ifid`=1, and `id_kill`=1 in N+1.
- The target instruction enters IF in N+2. Penalty: 2 slots taken, 0 not-taken.
- A load in EX feeding a branch gives 2 stall cycles. A load in MEM gives 1.
- An asynchronous reset in HOLD or REDIRECT returns to RUN immediately. A pending redirect is dropped.

## Structure
- Shared package `mips_pkg`: `br_op` encodings, `cmpsrc` codes, FSM state enum.
- One natural sub-module, `branch_cond`: combinational condition evaluation and target computation. FSM and counters live in the top.

## Test plan
- BEQ, cmpsrc=00/00, rs_data=rt_data=5, pc_plus4=0x100, imm=0x0004 → N+1: redirect_valid=1, redirect_pc=0x110, id_kill=1; br_cnt=taken_cnt=1.
- BNE, cmpsrc1=01, ex_result=7, rt_data=7 → not taken; no redirect; stays RUN.
- BGEZ, cmpsrc1=01, ex_memread=1, then sel becomes 10 with mem_memread=1, then 11 with wb_data=0x80000000 → stall_id high for 2 cycles, not taken; stall_cnt=2.
- J with pc_plus4=0xA0000004, jidx=0x0000010 → redirect_pc=0xA0000040. A BEQ presented during REDIRECT is ignored; br_cnt=1.
- rst_n low during HOLD → all outputs 0 in the same cycle; after release, the previous branch is not redirected.
- Preload counters near max (CNT_W=4, 15 taken branches) → the 16th taken branch wraps taken_cnt to 0.
